// File: rtl/cal_pkg.sv
// Shared constants and helpers for the calendar date keeper:
// field indices, Data layout, weekday encoding and date arithmetic.
package cal_pkg;

    localparam logic [1:0] FLD_DAY  = 2'd0;
    localparam logic [1:0] FLD_MON  = 2'd1;
    localparam logic [1:0] FLD_YEAR = 2'd2;

    localparam int DATA_DD_LSB = 0;
    localparam int DATA_MM_LSB = 8;
    localparam int DATA_YY_LSB = 16;

    typedef enum logic [2:0] {
        WD_SUN = 3'd0, WD_MON = 3'd1, WD_TUE = 3'd2, WD_WED = 3'd3,
        WD_THU = 3'd4, WD_FRI = 3'd5, WD_SAT = 3'd6
    } weekday_t;

    typedef enum logic [2:0] {
        EV_NONE, EV_CARRY, EV_LOAD, EV_INC, EV_DEC
    } ev_t;

    function automatic logic is_leap(input logic [13:0] y);
        return ((y % 14'd4) == 14'd0) &&
               (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
    endfunction

    function automatic logic [15:0] bin_to_bcd4(input logic [13:0] v);
        logic [3:0] d3, d2, d1, d0;
        d0 = 4'(v % 14'd10);
        d1 = 4'((v / 14'd10) % 14'd10);
        d2 = 4'((v / 14'd100) % 14'd10);
        d3 = 4'(v / 14'd1000);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
        logic [3:0] d1, d0;
        d0 = 4'(v % 7'd10);
        d1 = 4'(v / 7'd10);
        return {d1, d0};
    endfunction

    function automatic logic bcd_valid(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [1:0] first_set(input logic [2:0] v);
        if (v[0])      return FLD_DAY;
        else if (v[1]) return FLD_MON;
        else           return FLD_YEAR;
    endfunction

    // Sakamoto: the partial sum never goes negative because y >= y/100.
    function automatic logic [2:0] day_of_week(input logic [13:0] y,
                                               input logic [3:0]  m,
                                               input logic [4:0]  d);
        logic [13:0] yy;
        logic [2:0]  t;
        logic [14:0] s;
        yy = (m < 4'd3) ? y - 14'd1 : y;
        case (m)
            4'd1:    t = 3'd0;
            4'd2:    t = 3'd3;
            4'd3:    t = 3'd2;
            4'd4:    t = 3'd5;
            4'd5:    t = 3'd0;
            4'd6:    t = 3'd3;
            4'd7:    t = 3'd5;
            4'd8:    t = 3'd1;
            4'd9:    t = 3'd4;
            4'd10:   t = 3'd6;
            4'd11:   t = 3'd2;
            4'd12:   t = 3'd4;
            default: t = 3'd0;
        endcase
        s = {1'b0, yy} + {3'b0, yy[13:2]} - 15'(yy / 14'd100)
            + 15'(yy / 14'd400) + {12'b0, t} + {10'b0, d};
        return 3'(s % 15'd7);
    endfunction

endpackage

// File: rtl/cal_days_in_month.sv
// Days in a given month of a given Gregorian year.
module cal_days_in_month
    import cal_pkg::*;
(
    input  logic [3:0]  month,
    input  logic [13:0] year,
    output logic [4:0]  dim
);

    always_comb begin
        case (month)
            4'd2:                      dim = is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_gen.sv
// Date keeper: day carry, manual field edits, validated BCD load,
// registered BCD date, weekday and leap outputs.
module calendar_gen
    import cal_pkg::*;
#(
    parameter int YEAR_MIN   = 2000,
    parameter int YEAR_MAX   = 2099,
    parameter int INIT_YEAR  = 2025,
    parameter int INIT_MONTH = 9,
    parameter int INIT_DAY   = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        full_flag,
    input  logic [2:0]  cnt_inc,
    input  logic [2:0]  cnt_dec,
    input  logic        load,
    input  logic [31:0] load_data,
    output logic [31:0] Data,
    output logic [2:0]  weekday,
    output logic        leap,
    output logic        year_wrap,
    output logic        load_err
);

    localparam logic [13:0] Y_MIN  = 14'(YEAR_MIN);
    localparam logic [13:0] Y_MAX  = 14'(YEAR_MAX);
    localparam logic [13:0] Y_INIT = 14'(INIT_YEAR);
    localparam logic [3:0]  M_INIT = 4'(INIT_MONTH);
    localparam logic [4:0]  D_INIT = 5'(INIT_DAY);
    localparam logic [31:0] INIT_DATA = {bin_to_bcd4(Y_INIT),
                                         bin_to_bcd2(7'(INIT_MONTH)),
                                         bin_to_bcd2(7'(INIT_DAY))};
    localparam logic [2:0]  INIT_WD   = day_of_week(Y_INIT, M_INIT, D_INIT);
    localparam logic        INIT_LEAP = is_leap(Y_INIT);

    logic [13:0] year_q, nxt_y, tgt_y, ld_y;
    logic [3:0]  month_q, nxt_m, tgt_m;
    logic [4:0]  day_q, nxt_d, dim_cur, dim_tgt;
    logic [6:0]  ld_m, ld_d;
    logic [2:0]  inc_prev, dec_prev, inc_rise, dec_rise;
    logic [1:0]  fld;
    logic        ld_ok, wrap_nxt, err_nxt, wrap_pend;
    logic [31:0] data_n;
    ev_t         ev;

    assign inc_rise = cnt_inc & ~inc_prev;
    assign dec_rise = cnt_dec & ~dec_prev;

    assign ld_y = {10'b0, load_data[31:28]} * 14'd1000 + {10'b0, load_data[27:24]} * 14'd100
                + {10'b0, load_data[23:20]} * 14'd10   + {10'b0, load_data[19:16]};
    assign ld_m = {3'b0, load_data[15:12]} * 7'd10 + {3'b0, load_data[11:8]};
    assign ld_d = {3'b0, load_data[7:4]} * 7'd10 + {3'b0, load_data[3:0]};

    cal_days_in_month u_dim_cur (.month(month_q), .year(year_q), .dim(dim_cur));
    cal_days_in_month u_dim_tgt (.month(tgt_m),   .year(tgt_y),  .dim(dim_tgt));

    // Arbitration, then the month/year the event would land on (for clamp and load check).
    always_comb begin
        ev  = EV_NONE;
        fld = FLD_DAY;
        if (full_flag)        ev = EV_CARRY;
        else if (load)        ev = EV_LOAD;
        else if (|inc_rise) begin
            ev  = EV_INC;
            fld = first_set(inc_rise);
        end else if (|dec_rise) begin
            ev  = EV_DEC;
            fld = first_set(dec_rise);
        end

        tgt_y = year_q;
        tgt_m = month_q;
        case (ev)
            EV_LOAD: begin
                tgt_y = ld_y;
                tgt_m = ld_m[3:0];
            end
            EV_INC: begin
                if (fld == FLD_MON)  tgt_m = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                if (fld == FLD_YEAR) tgt_y = (year_q == Y_MAX) ? Y_MIN : year_q + 14'd1;
            end
            EV_DEC: begin
                if (fld == FLD_MON)  tgt_m = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
                if (fld == FLD_YEAR) tgt_y = (year_q == Y_MIN) ? Y_MAX : year_q - 14'd1;
            end
            default: ;
        endcase
    end

    assign ld_ok = bcd_valid(load_data) && (ld_y >= Y_MIN) && (ld_y <= Y_MAX)
                && (ld_m >= 7'd1) && (ld_m <= 7'd12)
                && (ld_d >= 7'd1) && (ld_d <= {2'b0, dim_tgt});

    always_comb begin
        nxt_y    = year_q;
        nxt_m    = month_q;
        nxt_d    = day_q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (ev)
            EV_CARRY: begin
                if (day_q < dim_cur) begin
                    nxt_d = day_q + 5'd1;
                end else begin
                    nxt_d = 5'd1;
                    if (month_q == 4'd12) begin
                        nxt_m = 4'd1;
                        if (year_q == Y_MAX) begin
                            nxt_y    = Y_MIN;
                            wrap_nxt = 1'b1;
                        end else begin
                            nxt_y = year_q + 14'd1;
                        end
                    end else begin
                        nxt_m = month_q + 4'd1;
                    end
                end
            end
            EV_LOAD: begin
                if (ld_ok) begin
                    nxt_y = ld_y;
                    nxt_m = ld_m[3:0];
                    nxt_d = ld_d[4:0];
                end else begin
                    err_nxt = 1'b1;
                end
            end
            EV_INC, EV_DEC: begin
                if (fld == FLD_DAY) begin
                    if (ev == EV_INC) nxt_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
                    else              nxt_d = (day_q == 5'd1) ? dim_cur : day_q - 5'd1;
                end else begin
                    nxt_y = tgt_y;
                    nxt_m = tgt_m;
                    nxt_d = (day_q > dim_tgt) ? dim_tgt : day_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_n = '0;
        data_n[DATA_YY_LSB +: 16] = bin_to_bcd4(year_q);
        data_n[DATA_MM_LSB +: 8]  = bin_to_bcd2({3'b0, month_q});
        data_n[DATA_DD_LSB +: 8]  = bin_to_bcd2({2'b0, day_q});
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            year_q    <= Y_INIT;
            month_q   <= M_INIT;
            day_q     <= D_INIT;
            inc_prev  <= '0;
            dec_prev  <= '0;
            wrap_pend <= 1'b0;
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
            Data      <= INIT_DATA;
            weekday   <= INIT_WD;
            leap      <= INIT_LEAP;
        end else begin
            year_q    <= nxt_y;
            month_q   <= nxt_m;
            day_q     <= nxt_d;
            inc_prev  <= cnt_inc;
            dec_prev  <= cnt_dec;
            wrap_pend <= wrap_nxt;
            year_wrap <= wrap_pend;
            load_err  <= err_nxt;
            Data      <= data_n;
            weekday   <= day_of_week(year_q, month_q, day_q);
            leap      <= is_leap(year_q);
        end
    end

endmodule

// File: tb/tb_calendar_gen.sv
// Directed bench for calendar_gen with hand-computed expected dates.
module tb_calendar_gen;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        full_flag;
    logic [2:0]  cnt_inc, cnt_dec;
    logic        load;
    logic [31:0] load_data;
    logic [31:0] Data;
    logic [2:0]  weekday;
    logic        leap, year_wrap, load_err;

    int vectors = 0;
    int miscompares = 0;

    calendar_gen dut (
        .Clk(Clk), .Reset(Reset), .full_flag(full_flag),
        .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .load(load), .load_data(load_data),
        .Data(Data), .weekday(weekday), .leap(leap),
        .year_wrap(year_wrap), .load_err(load_err)
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves time just after the edge that registered the load.
    task automatic do_load(input logic [31:0] v);
        load      = 1'b1;
        load_data = v;
        tick();
        load      = 1'b0;
    endtask

    task automatic pulse_full();
        full_flag = 1'b1;
        tick();
        full_flag = 1'b0;
        tick();
    endtask

    task automatic rise_inc(input logic [2:0] v);
        cnt_inc = v;
        tick();
        cnt_inc = 3'b000;
        tick();
    endtask

    task automatic rise_dec(input logic [2:0] v);
        cnt_dec = v;
        tick();
        cnt_dec = 3'b000;
        tick();
    endtask

    initial begin
        Reset = 1'b1; full_flag = 1'b0; cnt_inc = '0; cnt_dec = '0;
        load = 1'b0; load_data = '0;
        tick(2);
        check("reset_data", Data, 32'h20250906);
        check("reset_wd", {29'b0, weekday}, 32'd6);
        check("reset_leap", {31'b0, leap}, 32'd0);
        check("reset_wrap", {31'b0, year_wrap}, 32'd0);
        Reset = 1'b0;
        tick(3);
        check("idle_data", Data, 32'h20250906);

        // leap day carry
        do_load(32'h20240228);
        check("load_ok_err", {31'b0, load_err}, 32'd0);
        tick();
        check("load_data", Data, 32'h20240228);
        pulse_full();
        check("feb29_data", Data, 32'h20240229);
        check("feb29_leap", {31'b0, leap}, 32'd1);
        check("feb29_wd", {29'b0, weekday}, 32'd4);
        pulse_full();
        check("mar01_data", Data, 32'h20240301);
        check("mar01_wd", {29'b0, weekday}, 32'd5);

        // year range carry and wrap pulse timing
        do_load(32'h20991231);
        tick();
        full_flag = 1'b1;
        tick();
        full_flag = 1'b0;
        check("wrap_early", {31'b0, year_wrap}, 32'd0);
        check("wrap_data_early", Data, 32'h20991231);
        tick();
        check("wrap_data", Data, 32'h20000101);
        check("wrap_pulse", {31'b0, year_wrap}, 32'd1);
        check("wrap_wd", {29'b0, weekday}, 32'd6);
        check("wrap_leap", {31'b0, leap}, 32'd1);
        tick();
        check("wrap_one_cycle", {31'b0, year_wrap}, 32'd0);

        // clamp on month/year edits
        do_load(32'h20240131);
        tick();
        rise_inc(3'b010);
        check("clamp_mon_inc", Data, 32'h20240229);
        rise_inc(3'b100);
        check("clamp_year_inc", Data, 32'h20250228);
        rise_dec(3'b010);
        check("clamp_mon_dec", Data, 32'h20250128);

        // held bits step once, day wraps without carry
        do_load(32'h20250901);
        tick();
        cnt_dec = 3'b001;
        tick(100);
        check("hold_dec", Data, 32'h20250930);
        cnt_dec = 3'b000;
        tick();
        cnt_inc = 3'b001;
        tick(20);
        check("hold_inc", Data, 32'h20250901);
        cnt_inc = 3'b000;
        tick();

        // manual year wrap, no year_wrap pulse; multiple rising bits
        do_load(32'h20990615);
        tick();
        cnt_inc = 3'b100;
        tick();
        cnt_inc = 3'b000;
        tick();
        check("man_year_wrap", Data, 32'h20000615);
        check("man_no_pulse", {31'b0, year_wrap}, 32'd0);
        rise_inc(3'b110);
        check("lowest_bit", Data, 32'h20000715);

        // priority: carry beats inc in the same cycle
        do_load(32'h20250906);
        tick();
        full_flag = 1'b1;
        cnt_inc   = 3'b001;
        tick();
        full_flag = 1'b0;
        tick();
        cnt_inc = 3'b000;
        tick(2);
        check("carry_wins", Data, 32'h20250907);

        // rejected loads
        do_load(32'h20230229);
        check("rej_feb29_err", {31'b0, load_err}, 32'd1);
        tick();
        check("rej_err_one_cycle", {31'b0, load_err}, 32'd0);
        check("rej_data", Data, 32'h20250907);
        do_load(32'h202509A1);
        check("rej_nibble", {31'b0, load_err}, 32'd1);
        do_load(32'h20991301);
        check("rej_month", {31'b0, load_err}, 32'd1);
        do_load(32'h21000101);
        check("rej_year", {31'b0, load_err}, 32'd1);
        tick();
        check("rej_data_all", Data, 32'h20250907);

        // reset during held inc; bit still high at release counts as an edge
        do_load(32'h20240315);
        tick();
        cnt_inc = 3'b001;
        tick(3);
        check("pre_reset", Data, 32'h20240316);
        Reset = 1'b1;
        #1;
        check("reset_async", Data, 32'h20250906);
        check("reset_async_wd", {29'b0, weekday}, 32'd6);
        tick(2);
        Reset = 1'b0;
        tick(2);
        check("release_edge", Data, 32'h20250907);
        cnt_inc = 3'b000;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
